spart_rx_fifo: RTL and testbench
================================

Name: spart_rx_fifo

Overview:
Receive-side byte buffer between the SPART receiver shift register and the bus interface.
- Captures each byte the receiver completes, with its framing-error bit, into a small circular FIFO.
- Presents the oldest byte first-word-fall-through (FWFT) to the databus read path; rda reflects FIFO non-empty.
- Lets the driver tolerate back-to-back frames (e.g. A5, E7, 24) without losing data between reads.

Parameters:
DEPTH, 8, number of byte entries; power of two, at least 2
WIDTH, 8, data bits per entry
AFULL_LVL, 6, occupancy at or above which almost_full asserts; range 1 to DEPTH

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
rx_done  in  1  one-cycle pulse: receiver has completed a byte
rx_shift_reg  in  WIDTH  received byte, valid in the rx_done cycle
rx_frame_err  in  1  stop bit sampled low for this byte, valid with rx_done
rd_en  in  1  pop strobe from the bus interface (databus receive-buffer read)
rd_data  out  WIDTH  head byte (FWFT)
rd_ferr  out  1  framing-error bit of the head byte
rda  out  1  FIFO non-empty
full  out  1  occupancy equals DEPTH
almost_full  out  1  occupancy is at least AFULL_LVL
count  out  $clog2(DEPTH)+1  current occupancy
overrun  out  1  sticky: a byte was dropped because the FIFO was full
ovr_clr  in  1  clears overrun

Behaviour:
- All state updates on posedge clk. rst is sampled low at the clock edge and takes priority over every other input.
- Reset values: pointers 0, count 0, rda 0, full 0, almost_full 0, overrun 0, rd_data 0, rd_ferr 0. Memory contents are not reset.
- Storage: DEPTH x (WIDTH+1) array. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in a separate count register, not derived from the pointers.
- Push: rx_done=1 and (not full, or rd_en=1 with full) -> write {rx_frame_err, rx_shift_reg} at wptr; wptr+1.
- Pop: rd_en=1 and rda=1 -> rptr+1. rd_en while empty is ignored: no pointer move, no error.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push and pop when empty: push accepted, pop ignored. count becomes 1 and rda rises the next cycle.
- Simultaneous push and pop when full: both accepted, count stays DEPTH, overrun not set.
- Overflow: rx_done while full with no rd_en -> byte dropped, FIFO contents unchanged, overrun set the next cycle.
- overrun clear: ovr_clr=1 clears it. If a new overflow occurs in the same cycle, set wins and overrun stays 1.
- Latency:
  - Byte pushed at edge N is visible on rd_data and rda=1 after edge N (usable in cycle N+1).
  - Pop at edge N presents the next entry after edge N.
- rd_data and rd_ferr:
  - Non-empty: combinational reads of mem[rptr].
  - Empty: forced to 0.
- Status outputs: rda, full, almost_full are registered or decoded from the count register only, so they are glitch-free.
- Reset mid-operation, including during a pending rx_done: FIFO empties and the in-flight byte is discarded.
- No state machine beyond the pointer/count datapath. Control is a push/pop decision per cycle.

Decomposition:
- Shared package spart_pkg:
  - SPART_DATA_W = 8
  - typedef rx_entry_t = packed struct {ferr; data[7:0]}
  - ioaddr constants for receive buffer / status (reused by spart and driver)
- No sub-module. Storage is an inferred register array inside spart_rx_fifo.
- spart instantiates spart_rx_fifo between spart_rx and the databus mux.

Test Plan:
- Reset: hold rst=0 for 3 cycles with rx_done pulsing -> count=0, rda=0, rd_data=0x00, overrun=0 after release.
- Single byte: pulse rx_done with 0xA5 -> next cycle rda=1, rd_data=0xA5, count=1. Then rd_en for 1 cycle -> rda=0, rd_data=0x00.
- Ordering and ferr: push 0xA5 (ferr=0), 0xE7 (ferr=1), 0x24 (ferr=0) -> pops return A5/0, E7/1, 24/0 in order, count 3→0.
- Fill, almost_full and overflow: push 0x00..0x07 -> almost_full at count=6, full at count=8. Push 0xFF with no rd_en -> overrun=1, count=8. Drain yields 0x00..0x07 with no 0xFF.
- Full with simultaneous push and pop: FIFO full with head 0x00, pulse rx_done 0x5A together with rd_en -> count stays 8, overrun stays 0, 0x5A is the last byte drained. Then ovr_clr together with an overflow -> overrun remains 1.
- Wrap-around: 20 push/pop pairs of incrementing bytes, 0x10..0x23, at count≤3 -> every popped byte matches, pointers wrap with no loss or duplication.

Source files
------------

// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART types and constants.
//   SPART_DATA_W : byte width used by the receiver, FIFO and databus
//   rx_entry_t   : one received byte with its framing-error flag
//   ioaddr_t     : register addresses shared by spart and its driver
package spart_pkg;

   localparam int SPART_DATA_W = 8;

   typedef struct packed {
      logic                    ferr;
      logic [SPART_DATA_W-1:0] data;
   } rx_entry_t;

   typedef enum logic [1:0] {
      IOADDR_BUF     = 2'b00,
      IOADDR_STATUS  = 2'b01,
      IOADDR_DB_LOW  = 2'b10,
      IOADDR_DB_HIGH = 2'b11
   } ioaddr_t;

endpackage

// File: rtl/spart_rx_fifo_if.sv
// spart_rx_fifo_if: receiver-push / bus-pop signals of the SPART receive FIFO.
//   master : receiver and bus side; drives rx_done, rx_shift_reg, rx_frame_err, rd_en, ovr_clr
//   slave  : FIFO side; drives rd_data, rd_ferr, rda, full, almost_full, count, overrun
interface spart_rx_fifo_if #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             rx_done;
   logic [WIDTH-1:0] rx_shift_reg;
   logic             rx_frame_err;
   logic             rd_en;
   logic             ovr_clr;
   logic [WIDTH-1:0] rd_data;
   logic             rd_ferr;
   logic             rda;
   logic             full;
   logic             almost_full;
   logic [CW-1:0]    count;
   logic             overrun;

   modport master (
      output rx_done, rx_shift_reg, rx_frame_err, rd_en, ovr_clr,
      input  rd_data, rd_ferr, rda, full, almost_full, count, overrun
   );

   modport slave (
      input  rx_done, rx_shift_reg, rx_frame_err, rd_en, ovr_clr,
      output rd_data, rd_ferr, rda, full, almost_full, count, overrun
   );

endinterface

// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: first-word-fall-through byte FIFO between the SPART receiver and the databus.
//   clk : system clock
//   rst : synchronous reset, active-low
//   bus : spart_rx_fifo_if.slave -- push (rx_done/rx_shift_reg/rx_frame_err), pop (rd_en),
//         head byte (rd_data/rd_ferr), status (rda/full/almost_full/count), sticky overrun/ovr_clr
module spart_rx_fifo
   import spart_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = SPART_DATA_W,
   parameter int AFULL_LVL = 6
) (
   input logic            clk,
   input logic            rst,
   spart_rx_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH:0]  mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overrun_q, overrun_d;
   logic            rda, full, push, pop, overflow;

   // Status is decoded from the count register only, so it never glitches.
   assign rda  = count_q != '0;
   assign full = count_q == CW'(DEPTH);

   // A full FIFO still accepts a byte when the same cycle pops one.
   assign push     = bus.rx_done & (~full | bus.rd_en);
   assign pop      = bus.rd_en & rda;
   assign overflow = bus.rx_done & full & ~bus.rd_en;

   always_comb begin
      wptr_d    = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d    = pop ? rptr_q + AW'(1) : rptr_q;
      count_d   = count_q + CW'(push) - CW'(pop);
      // A new overflow beats a clear in the same cycle.
      overrun_d = overflow ? 1'b1 : bus.ovr_clr ? 1'b0 : overrun_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage is not reset; a byte arriving during reset is discarded.
   always_ff @(posedge clk) begin
      if (rst && push) mem_q[wptr_q] <= {bus.rx_frame_err, bus.rx_shift_reg};
   end

   assign bus.rd_data     = rda ? mem_q[rptr_q][WIDTH-1:0] : '0;
   assign bus.rd_ferr     = rda ? mem_q[rptr_q][WIDTH] : 1'b0;
   assign bus.rda         = rda;
   assign bus.full        = full;
   assign bus.almost_full = count_q >= CW'(AFULL_LVL);
   assign bus.count       = count_q;
   assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// tb_spart_rx_fifo: directed and random stimulus checked every cycle against a queue model.
module tb_spart_rx_fifo;

   localparam int DEPTH = 8;
   localparam int AFULL = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic chk_en = 1'b0;
   int   n_pass = 0;
   int   n_tot  = 0;

   logic [8:0] mq[$];
   logic       m_ovr = 1'b0;

   always #5 clk = ~clk;

   spart_rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(8)) bif ();

   spart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(8), .AFULL_LVL(AFULL)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif.slave)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Model: occupancy is the queue length; the head is the front of the queue.
   task automatic model_step(input logic r, input logic rd, input logic rx, input logic [7:0] b,
                             input logic fe, input logic clr);
      int  n;
      logic do_pop, do_push, ovf;
      n = mq.size();
      if (!r) begin
         mq.delete();
         m_ovr = 1'b0;
      end else begin
         do_pop  = rd && n > 0;
         do_push = rx && (n < DEPTH || rd);
         ovf     = rx && n == DEPTH && !rd;
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back({fe, b});
         m_ovr = ovf ? 1'b1 : clr ? 1'b0 : m_ovr;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         n = mq.size();
         check("rd_data", int'(bif.rd_data), n > 0 ? int'(mq[0][7:0]) : 0);
         check("rd_ferr", int'(bif.rd_ferr), n > 0 ? int'(mq[0][8]) : 0);
         check("rda", int'(bif.rda), int'(n > 0));
         check("full", int'(bif.full), int'(n == DEPTH));
         check("almost_full", int'(bif.almost_full), int'(n >= AFULL));
         check("count", int'(bif.count), n);
         check("overrun", int'(bif.overrun), int'(m_ovr));
      end
   end

   // One clock: drive inputs, take the edge, advance the model, return at the falling edge.
   task automatic cyc(input logic rd, input logic rx, input logic [7:0] b,
                      input logic fe = 1'b0, input logic clr = 1'b0);
      bif.rd_en = rd;
      bif.rx_done = rx;
      bif.rx_shift_reg = b;
      bif.rx_frame_err = fe;
      bif.ovr_clr = clr;
      @(posedge clk);
      model_step(rst, rd, rx, b, fe, clr);
      chk_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic pop_expect(input logic [7:0] b, input logic fe, input string name);
      check({name, "_data"}, int'(bif.rd_data), int'(b));
      check({name, "_ferr"}, int'(bif.rd_ferr), int'(fe));
      cyc(1'b1, 1'b0, 8'h00);
   endtask

   initial begin
      bif.rd_en = 1'b0;
      bif.rx_done = 1'b0;
      bif.rx_shift_reg = 8'h00;
      bif.rx_frame_err = 1'b0;
      bif.ovr_clr = 1'b0;
      @(negedge clk);

      // Reset held with rx_done pulsing
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h5C);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);
      check("rst_count", int'(bif.count), 0);
      check("rst_rda", int'(bif.rda), 0);
      check("rst_data", int'(bif.rd_data), 0);
      check("rst_ovr", int'(bif.overrun), 0);

      // Single byte
      cyc(1'b0, 1'b1, 8'hA5);
      check("single_rda", int'(bif.rda), 1);
      check("single_data", int'(bif.rd_data), 'hA5);
      check("single_count", int'(bif.count), 1);
      cyc(1'b1, 1'b0, 8'h00);
      check("single_rda0", int'(bif.rda), 0);
      check("single_data0", int'(bif.rd_data), 0);

      // Ordering with framing-error bits
      cyc(1'b0, 1'b1, 8'hA5, 1'b0);
      cyc(1'b0, 1'b1, 8'hE7, 1'b1);
      cyc(1'b0, 1'b1, 8'h24, 1'b0);
      check("ord_count3", int'(bif.count), 3);
      pop_expect(8'hA5, 1'b0, "ord0");
      pop_expect(8'hE7, 1'b1, "ord1");
      pop_expect(8'h24, 1'b0, "ord2");
      check("ord_count0", int'(bif.count), 0);

      // Push and pop together while empty: push wins
      cyc(1'b1, 1'b1, 8'h3C);
      check("emp_pp_count", int'(bif.count), 1);
      pop_expect(8'h3C, 1'b0, "emp_pp");

      // Fill, almost_full, overflow
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b0, 1'b1, 8'(i));
         if (i == 4) check("afull_at5", int'(bif.almost_full), 0);
         if (i == 5) check("afull_at6", int'(bif.almost_full), 1);
         if (i == 6) check("full_at7", int'(bif.full), 0);
      end
      check("full_at8", int'(bif.full), 1);
      cyc(1'b0, 1'b1, 8'hFF);
      check("ovf_ovr", int'(bif.overrun), 1);
      check("ovf_count", int'(bif.count), 8);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("ovr_cleared", int'(bif.overrun), 0);

      // Full with simultaneous push and pop, then clear racing an overflow
      check("fpp_head", int'(bif.rd_data), 0);
      cyc(1'b1, 1'b1, 8'h5A);
      check("fpp_count", int'(bif.count), 8);
      check("fpp_ovr", int'(bif.overrun), 0);
      cyc(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
      check("clr_vs_ovf", int'(bif.overrun), 1);
      for (int i = 1; i < DEPTH; i++) pop_expect(8'(i), 1'b0, "drain");
      pop_expect(8'h5A, 1'b0, "drain_last");
      check("drain_empty", int'(bif.rda), 0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Wrap-around
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b1, 8'(8'h10 + i));
         pop_expect(8'(8'h10 + i), 1'b0, "wrap");
      end
      check("wrap_count", int'(bif.count), 0);

      // Random traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 79) != 0);
         cyc(1'($urandom_range(0, 99) < (i < 300 ? 30 : 70)),
             1'($urandom_range(0, 99) < (i < 300 ? 70 : 35)),
             8'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0));
      end
      rst = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
